// File: rtl/vdp_video_io_driver_if.sv
// rtl/vdp_video_io_driver_if.sv - pixel stream and video pin bundle between VDP and raster driver
interface vdp_video_io_driver_if;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [11:0] pixel_data;
    logic [16:0] video_io;

    modport master (
        output pixel_valid,
        output pixel_data,
        input  pixel_ready,
        input  video_io
    );

    modport slave (
        input  pixel_valid,
        input  pixel_data,
        output pixel_ready,
        output video_io
    );
endinterface

// File: rtl/vdp_video_io_driver.sv
// rtl/vdp_video_io_driver.sv - raster timing generator with pixel FIFO driving the video_io pin bundle
module vdp_video_io_driver #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    vdp_video_io_driver_if.slave io
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    // {holding_raster, line_ended, frame_ended, vsync, hsync, rgb}
    localparam logic [16:0] IDLE_WORD = {1'b1, 1'b0, 1'b0, !SYNC_ACTIVE, !SYNC_ACTIVE, 12'h000};

    logic [11:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full, fifo_empty, push, pop;

    logic [HW-1:0] h, h_next;
    logic [VW-1:0] v, v_next;
    logic [16:0]   video_q, video_next;
    logic          active, stall, line_end, frame_end, hsync_lvl, vsync_lvl;

    assign fifo_full      = (count == FULL_CNT);
    assign fifo_empty     = (count == '0);
    assign push           = io.pixel_valid && !fifo_full;
    assign io.pixel_ready = !fifo_full;
    assign io.video_io    = video_q;

    assign active    = (h < H_VIS) && (v < V_VIS);
    assign stall     = enable && active && fifo_empty;
    assign pop       = enable && active && !fifo_empty;
    assign line_end  = (h == H_LAST);
    assign frame_end = line_end && (v == V_LAST);
    assign hsync_lvl = (h >= HS_START && h < HS_END) ? SYNC_ACTIVE : !SYNC_ACTIVE;
    assign vsync_lvl = (v >= VS_START && v < VS_END) ? SYNC_ACTIVE : !SYNC_ACTIVE;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= io.pixel_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A stall freezes the position but still tracks sync from it; no FIFO bypass,
    // so a pixel pushed this clock cannot release a stall until the next one.
    always_comb begin
        h_next     = h;
        v_next     = v;
        video_next = IDLE_WORD;
        if (!enable) begin
            h_next = '0;
            v_next = '0;
        end else if (stall) begin
            video_next = {1'b1, 1'b0, 1'b0, vsync_lvl, hsync_lvl, 12'h000};
        end else begin
            video_next = {1'b0, line_end, frame_end, vsync_lvl, hsync_lvl,
                          active ? mem[rd_ptr] : 12'h000};
            if (line_end) begin
                h_next = '0;
                v_next = (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h_next = h + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            h       <= '0;
            v       <= '0;
            video_q <= IDLE_WORD;
        end else begin
            h       <= h_next;
            v       <= v_next;
            video_q <= video_next;
        end
    end
endmodule
